// File: rtl/if_fetch.sv
// Instruction-fetch stage: drives a 1-cycle-latency instruction memory and registers
// the fetched word and its PC for decode, with a 1-entry buffer absorbing decode stalls.
module if_fetch #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [15:0]       NOP_INSN = 16'h0000
) (
  input  logic              clk_if,
  input  logic              rst_if,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instruction,
  output logic [ADDR_W-1:0] pc_if,
  output logic              inst_valid
);

  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_buf_valid;
  logic [15:0]       r_buf_insn;
  logic [ADDR_W-1:0] r_buf_pc;
  logic [15:0]       r_instruction;
  logic [ADDR_W-1:0] r_pc_if;
  logic              r_inst_valid;
  logic              w_req;

  // A request is only issued when its data is guaranteed a home next cycle.
  assign w_req     = !rst_if && !stall && !br_taken;
  assign imem_req  = w_req;
  assign imem_addr = r_pc;

  assign instruction = r_instruction;
  assign pc_if       = r_pc_if;
  assign inst_valid  = r_inst_valid;

  always_ff @(posedge clk_if) begin
    if (rst_if) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_buf_valid   <= 1'b0;
      r_buf_insn    <= NOP_INSN;
      r_buf_pc      <= '0;
      r_instruction <= NOP_INSN;
      r_pc_if       <= '0;
      r_inst_valid  <= 1'b0;
    end else begin
      if (w_req) begin
        r_pc          <= r_pc + PC_STEP;
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_pc;
      end else begin
        r_inflight    <= 1'b0;
      end

      if (br_taken) begin
        // Redirect squashes both the in-flight read and any buffered word.
        r_pc          <= br_target;
        r_buf_valid   <= 1'b0;
        r_inst_valid  <= 1'b0;
        r_instruction <= NOP_INSN;
      end else if (stall) begin
        if (r_inflight) begin
          r_buf_valid <= 1'b1;
          r_buf_insn  <= imem_rdata;
          r_buf_pc    <= r_inflight_pc;
        end
      end else if (r_buf_valid) begin
        r_instruction <= r_buf_insn;
        r_pc_if       <= r_buf_pc;
        r_inst_valid  <= 1'b1;
        r_buf_valid   <= 1'b0;
      end else if (r_inflight) begin
        r_instruction <= imem_rdata;
        r_pc_if       <= r_inflight_pc;
        r_inst_valid  <= 1'b1;
      end else begin
        r_instruction <= NOP_INSN;
        r_inst_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a queue-based model of the fetch stream checked every cycle,
// plus literal expectations for reset, branch bubbles, stall/branch and PC wrap.
module tb_if_fetch;

  logic        clk_if = 1'b0;
  logic        rst_if = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] instruction;
  logic [15:0] pc_if;
  logic        inst_valid;

  // Second instance exercises the PC wrap from a non-zero reset PC.
  logic        tie0 = 1'b0;
  logic [15:0] tie0_w = 16'h0000;
  logic        imem_req2;
  logic [15:0] imem_addr2;
  logic [15:0] imem_rdata2;
  logic [15:0] instruction2;
  logic [15:0] pc_if2;
  logic        inst_valid2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_if = ~clk_if;

  if_fetch dut (
    .clk_if(clk_if), .rst_if(rst_if), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instruction(instruction), .pc_if(pc_if),
    .inst_valid(inst_valid)
  );

  if_fetch #(.RESET_PC(16'hFFFE)) dut2 (
    .clk_if(clk_if), .rst_if(rst_if), .stall(tie0), .br_taken(tie0),
    .br_target(tie0_w), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .instruction(instruction2), .pc_if(pc_if2),
    .inst_valid(inst_valid2)
  );

  // Synchronous memory: imem[a] = 0x0100 + a.
  always @(posedge clk_if) begin
    if (imem_req)  imem_rdata  <= 16'h0100 + imem_addr;
    if (imem_req2) imem_rdata2 <= 16'h0100 + imem_addr2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: fetched-but-undelivered PCs wait in a queue; decode sees them in order.
  logic [15:0] m_fetch;
  logic [15:0] m_q[$];
  logic        m_valid;
  logic [15:0] m_insn;
  logic [15:0] m_pc;

  task automatic model_edge();
    logic [15:0] p;
    if (rst_if) begin
      m_fetch = 16'h0000;
      m_q.delete();
      m_valid = 1'b0;
      m_insn  = 16'h0000;
      m_pc    = 16'h0000;
    end else if (br_taken) begin
      m_fetch = br_target;
      m_q.delete();
      m_valid = 1'b0;
      m_insn  = 16'h0000;
    end else if (!stall) begin
      if (m_q.size() > 0) begin
        p       = m_q.pop_front();
        m_valid = 1'b1;
        m_pc    = p;
        m_insn  = 16'h0100 + p;
      end else begin
        m_valid = 1'b0;
        m_insn  = 16'h0000;
      end
      m_q.push_back(m_fetch);
      m_fetch = m_fetch + 16'h0001;
    end
  endtask

  initial begin
    @(posedge clk_if);
    model_edge();
    forever begin
      @(negedge clk_if);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
      chk("instruction", {16'b0, instruction}, {16'b0, m_insn});
      chk("pc_if", {16'b0, pc_if}, {16'b0, m_pc});
      chk("imem_req", {31'b0, imem_req}, {31'b0, (!rst_if && !stall && !br_taken)});
      chk("imem_addr", {16'b0, imem_addr}, {16'b0, m_fetch});
      @(posedge clk_if);
      model_edge();
    end
  end

  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t);
    rst_if = r; stall = s; br_taken = b; br_target = t;
    @(posedge clk_if);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic lit(input string name, input logic v, input logic [15:0] p, input logic [15:0] ins);
    chk({name, " valid"}, {31'b0, inst_valid}, {31'b0, v});
    chk({name, " insn"}, {16'b0, instruction}, {16'b0, ins});
    if (v) chk({name, " pc"}, {16'b0, pc_if}, {16'b0, p});
  endtask

  task automatic lit2(input string name, input logic [15:0] p, input logic [15:0] ins);
    chk({name, " valid"}, {31'b0, inst_valid2}, 32'd1);
    chk({name, " insn"}, {16'b0, instruction2}, {16'b0, ins});
    chk({name, " pc"}, {16'b0, pc_if2}, {16'b0, p});
  endtask

  initial begin
    @(posedge clk_if); #1;
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    lit("reset", 1'b0, 16'h0000, 16'h0000);
    chk("reset pc_if", {16'b0, pc_if}, 32'h0);

    // Run from reset, then branch to 0x0040 in cycle 5.
    run(2);
    lit("c2", 1'b1, 16'h0000, 16'h0100); lit2("wrap c2", 16'hFFFE, 16'h00FE);
    run(1);
    lit("c3", 1'b1, 16'h0001, 16'h0101); lit2("wrap c3", 16'hFFFF, 16'h00FF);
    run(1);
    lit("c4", 1'b1, 16'h0002, 16'h0102); lit2("wrap c4", 16'h0000, 16'h0100);
    run(1);
    lit("c5", 1'b1, 16'h0003, 16'h0103); lit2("wrap c5", 16'h0001, 16'h0101);
    step(1'b0, 1'b0, 1'b1, 16'h0040);
    lit("br c6", 1'b0, 16'h0000, 16'h0000);
    run(1);
    lit("br c7", 1'b0, 16'h0000, 16'h0000);
    run(1);
    lit("br c8", 1'b1, 16'h0040, 16'h0140);

    // One-cycle stall then three-cycle stall mid-stream.
    run(2);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    run(1);
    repeat (3) step(1'b0, 1'b1, 1'b0, 16'h0000);
    run(6);

    // Branch while stalled with the buffer full.
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 16'h0040);
    lit("sbr +1", 1'b0, 16'h0000, 16'h0000);
    run(1);
    lit("sbr +2", 1'b0, 16'h0000, 16'h0000);
    run(1);
    lit("sbr +3", 1'b1, 16'h0040, 16'h0140);
    run(1);
    lit("sbr +4", 1'b1, 16'h0041, 16'h0141);

    // Reset during a stall with the buffer full.
    run(3);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    lit("rst r0", 1'b0, 16'h0000, 16'h0000);
    run(1);
    lit("rst r1", 1'b0, 16'h0000, 16'h0000);
    run(1);
    lit("rst r2", 1'b1, 16'h0000, 16'h0100);
    run(1);
    lit("rst r3", 1'b1, 16'h0001, 16'h0101);
    run(3);

    @(negedge clk_if); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
